// File: rtl/pila_if.sv
// pila_if: bus between the control unit / fetch stage and the return-address
// stack "pila".
//   master modport (control unit side): drives push, pop, din, clr_err and
//                                       observes dout, count, empty, full, ovf, unf.
//   slave modport  (pila side)        : the mirror image.
// Parameters DEPTH and AW must match the ones given to the pila instance.
interface pila_if #(
    parameter int DEPTH = 16,
    parameter int AW    = 10
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          push;
    logic          pop;
    logic [AW-1:0] din;
    logic          clr_err;
    logic [AW-1:0] dout;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;

    modport master (
        output push, pop, din, clr_err,
        input  dout, count, empty, full, ovf, unf
    );

    modport slave (
        input  push, pop, din, clr_err,
        output dout, count, empty, full, ovf, unf
    );
endinterface

// File: rtl/pila.sv
// pila: return-address stack for the 16-bit CPU.
//   Stores PC+1 on push, presents the top entry combinationally on dout so the
//   PC mux can load it in the same cycle as pop. Tracks occupancy, full/empty
//   and sticky overflow/underflow flags.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (clears pointers, count, flags;
//            the entry array itself is not reset)
//   bus      pila_if.slave: push, pop, din, clr_err in; dout, count, empty,
//            full, ovf, unf out
// Configuration macro: PILA_WRAP_EN
//   defined   - push while full overwrites the oldest entry (count stays DEPTH)
//   undefined - push while full is dropped
//   ovf is set on push-while-full in both builds.
module pila #(
    parameter int DEPTH = 16,
    parameter int AW    = 10
) (
    input  logic   clk,
    input  logic   reset_n,
    pila_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    // Pointer arithmetic helpers; wrap modulo DEPTH through the natural width.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return p + PTR_ONE;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return p - PTR_ONE;
    endfunction

    logic [AW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wp_r;
    logic [CW-1:0] count_r;
    logic          ovf_r;
    logic          unf_r;

    logic          empty_s;
    logic          full_s;
    logic [PW-1:0] top_ptr_s;
    logic [PW-1:0] wp_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic          mem_we_s;
    logic [PW-1:0] mem_wa_s;
    logic          ovf_set_s;
    logic          unf_set_s;

    assign empty_s   = (count_r == CNT_ZERO);
    assign full_s    = (count_r == CNT_DEPTH);
    assign top_ptr_s = ptr_dec(wp_r);

    // Next-state decode for pointer, count, entry write and error events.
    always_comb begin
        wp_nxt_s    = wp_r;
        count_nxt_s = count_r;
        mem_we_s    = 1'b0;
        mem_wa_s    = wp_r;
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        case ({bus.push, bus.pop})
            2'b10: begin
                if (!full_s) begin
                    mem_we_s    = 1'b1;
                    mem_wa_s    = wp_r;
                    wp_nxt_s    = ptr_inc(wp_r);
                    count_nxt_s = count_r + CNT_ONE;
                end else begin
                    ovf_set_s = 1'b1;
`ifdef PILA_WRAP_EN
                    // Overwrite the oldest slot: when full, wp points at it.
                    mem_we_s  = 1'b1;
                    mem_wa_s  = wp_r;
                    wp_nxt_s  = ptr_inc(wp_r);
`else
                    mem_we_s  = 1'b0;
`endif
                end
            end
            2'b01: begin
                if (!empty_s) begin
                    wp_nxt_s    = ptr_dec(wp_r);
                    count_nxt_s = count_r - CNT_ONE;
                end else begin
                    unf_set_s = 1'b1;
                end
            end
            2'b11: begin
                if (!empty_s) begin
                    // Replace the top entry in place; depth is unchanged.
                    mem_we_s = 1'b1;
                    mem_wa_s = top_ptr_s;
                end else begin
                    // Empty: behaves as a plain push, no underflow recorded.
                    mem_we_s    = 1'b1;
                    mem_wa_s    = wp_r;
                    wp_nxt_s    = ptr_inc(wp_r);
                    count_nxt_s = count_r + CNT_ONE;
                end
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Entry storage; deliberately not reset so it maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= bus.din;
        end
    end

    // Pointer, occupancy and sticky error flags; a new error event wins over clr_err.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_r    <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            wp_r    <= wp_nxt_s;
            count_r <= count_nxt_s;
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (unf_set_s) begin
                unf_r <= 1'b1;
            end else if (bus.clr_err) begin
                unf_r <= 1'b0;
            end else begin
                unf_r <= unf_r;
            end
        end
    end

    // dout is combinational from state so pop and the PC load share one edge.
    assign bus.dout  = empty_s ? AW'(0) : mem_r[top_ptr_s];
    assign bus.count = count_r;
    assign bus.empty = empty_s;
    assign bus.full  = full_s;
    assign bus.ovf   = ovf_r;
    assign bus.unf   = unf_r;
endmodule

// File: tb/tb_pila.sv
module tb_pila;
    localparam int DEPTH = 16;
    localparam int AW    = 10;

    logic clk;
    logic reset_n;

    pila_if #(.DEPTH(DEPTH), .AW(AW)) bus_if ();

    pila #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: a queue whose back is the top of stack.
    logic [AW-1:0] mq[$];
    logic          m_ovf;
    logic          m_unf;
    logic [AW-1:0] pre_dout;

    typedef struct {
        logic          p;
        logic          o;
        logic [AW-1:0] d;
        logic          c;
        int            ec;
        logic [AW-1:0] ed;
        logic          eo;
        logic          eu;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus; sample dout mid-cycle (before the edge),
    // then advance the model and land 1 time unit after the edge.
    task automatic step(input logic p, input logic o, input logic [AW-1:0] d, input logic c);
        logic ev_o;
        logic ev_u;
        @(negedge clk);
        bus_if.push    = p;
        bus_if.pop     = o;
        bus_if.din     = d;
        bus_if.clr_err = c;
        #1;
        pre_dout = bus_if.dout;
        @(posedge clk);
        ev_o = 1'b0;
        ev_u = 1'b0;
        if (p && !o) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(d);
            end else begin
                ev_o = 1'b1;
`ifdef PILA_WRAP_EN
                void'(mq.pop_front());
                mq.push_back(d);
`endif
            end
        end else if (!p && o) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else ev_u = 1'b1;
        end else if (p && o) begin
            if (mq.size() > 0) mq[mq.size()-1] = d;
            else mq.push_back(d);
        end
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (ev_o) m_ovf = 1'b1;
        if (ev_u) m_unf = 1'b1;
        #1;
    endtask

    task automatic chk_model(input string tag);
        int ecount;
        logic [AW-1:0] etop;
        ecount = mq.size();
        etop   = (ecount > 0) ? mq[ecount-1] : '0;
        chk({tag, "_count"}, int'(bus_if.count), ecount);
        chk({tag, "_dout"},  int'(bus_if.dout),  int'(etop));
        chk({tag, "_empty"}, int'(bus_if.empty), (ecount == 0) ? 1 : 0);
        chk({tag, "_full"},  int'(bus_if.full),  (ecount == DEPTH) ? 1 : 0);
        chk({tag, "_ovf"},   int'(bus_if.ovf),   int'(m_ovf));
        chk({tag, "_unf"},   int'(bus_if.unf),   int'(m_unf));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 10'h005, 1'b0, 1, 10'h005, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 10'h0A3, 1'b0, 2, 10'h0A3, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 10'h3FF, 1'b0, 3, 10'h3FF, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 10'h000, 1'b0, 2, 10'h0A3, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 10'h000, 1'b0, 1, 10'h005, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 10'h000, 1'b0, 0, 10'h000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 10'h000, 1'b0, 0, 10'h000, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 10'h000, 1'b1, 0, 10'h000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 10'h000, 1'b1, 0, 10'h000, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 10'h000, 1'b1, 0, 10'h000, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 10'h077, 1'b0, 1, 10'h077, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 10'h000, 1'b0, 0, 10'h000, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 10'h020, 1'b0, 1, 10'h020, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 10'h021, 1'b0, 2, 10'h021, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 10'h2AA, 1'b0, 2, 10'h2AA, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 10'h000, 1'b0, 1, 10'h020, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 10'h000, 1'b0, 0, 10'h000, 1'b0, 1'b0};

        reset_n        = 1'b0;
        bus_if.push    = 1'b0;
        bus_if.pop     = 1'b0;
        bus_if.din     = '0;
        bus_if.clr_err = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #12;
        chk("rst_count", int'(bus_if.count), 0);
        chk("rst_empty", int'(bus_if.empty), 1);
        chk("rst_full",  int'(bus_if.full),  0);
        chk("rst_ovf",   int'(bus_if.ovf),   0);
        chk("rst_unf",   int'(bus_if.unf),   0);
        chk("rst_dout",  int'(bus_if.dout),  0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors from the table, constant expectations.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].p, tbl[i].o, tbl[i].d, tbl[i].c);
            chk($sformatf("tbl%0d_count", i), int'(bus_if.count), tbl[i].ec);
            chk($sformatf("tbl%0d_dout", i),  int'(bus_if.dout),  int'(tbl[i].ed));
            chk($sformatf("tbl%0d_ovf", i),   int'(bus_if.ovf),   int'(tbl[i].eo));
            chk($sformatf("tbl%0d_unf", i),   int'(bus_if.unf),   int'(tbl[i].eu));
            chk($sformatf("tbl%0d_empty", i), int'(bus_if.empty), (tbl[i].ec == 0) ? 1 : 0);
        end

        // Same-cycle dout on pop: push two, pop shows top before the edge.
        step(1'b1, 1'b0, 10'h155, 1'b0);
        step(1'b1, 1'b0, 10'h0AA, 1'b0);
        step(1'b0, 1'b1, 10'h000, 1'b0);
        chk("pop_same_cycle_dout0", int'(pre_dout), 'h0AA);
        step(1'b0, 1'b1, 10'h000, 1'b0);
        chk("pop_same_cycle_dout1", int'(pre_dout), 'h155);

        // Fill to full, then push once more.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, AW'(10'h010 + i), 1'b0);
        chk("fill_full",  int'(bus_if.full),  1);
        chk("fill_count", int'(bus_if.count), DEPTH);
        chk("fill_dout",  int'(bus_if.dout),  'h01F);
        chk("fill_ovf",   int'(bus_if.ovf),   0);
        step(1'b1, 1'b0, 10'h111, 1'b0);
        chk("ovf_set",   int'(bus_if.ovf),   1);
        chk("ovf_full",  int'(bus_if.full),  1);
        chk("ovf_count", int'(bus_if.count), DEPTH);
`ifdef PILA_WRAP_EN
        chk("ovf_dout", int'(bus_if.dout), 'h111);
`else
        chk("ovf_dout", int'(bus_if.dout), 'h01F);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            int exp_v;
`ifdef PILA_WRAP_EN
            exp_v = (i == 0) ? 'h111 : ('h020 - i);
`else
            exp_v = 'h01F - i;
`endif
            step(1'b0, 1'b1, 10'h000, 1'b0);
            chk($sformatf("drain%0d", i), int'(pre_dout), exp_v);
        end
        chk("drain_empty", int'(bus_if.empty), 1);
        chk("drain_unf",   int'(bus_if.unf),   0);
        chk("drain_ovf_sticky", int'(bus_if.ovf), 1);
        // Overflow event together with clr_err: set wins.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, AW'(i), 1'b0);
        step(1'b1, 1'b0, 10'h3C3, 1'b1);
        chk("ovf_set_wins", int'(bus_if.ovf), 1);
        step(1'b0, 1'b0, 10'h000, 1'b1);
        chk("ovf_cleared", int'(bus_if.ovf), 0);
        chk_model("post_ovf");

        // Asynchronous reset mid-cycle with entries present.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 10'h000, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, AW'(10'h040 + i), 1'b0);
        chk("pre_rst_count", int'(bus_if.count), 5);
        @(negedge clk);
        bus_if.push = 1'b0;
        bus_if.pop  = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_count", int'(bus_if.count), 0);
        chk("async_rst_empty", int'(bus_if.empty), 1);
        chk("async_rst_dout",  int'(bus_if.dout),  0);
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 1'b1, 10'h000, 1'b0);
        chk("post_rst_unf",  int'(bus_if.unf),  1);
        chk("post_rst_dout", int'(bus_if.dout), 0);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 800; n++) begin
            logic p;
            logic o;
            logic c;
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 6);
            step(p, o, AW'($urandom_range(0, 1023)), c);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
